step_generator: RTL and testbench

STEP_GENERATOR -- requirements
Module: step_generator

---
 rtl/step_generator.sv | 228 ++++++++++++++++++++++
 tb/tb_step_generator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_generator.sv
`default_nettype none
// ============================================================================
// Module   : step_generator
// Purpose  : Multi-channel step/dir pulse generator behind a word-addressed bus.
// Revision : 1.0 - initial release
// ============================================================================
module step_generator #(
  parameter int NUM_CHANNELS = 12,
  parameter int PERIOD_WIDTH = 16,
  parameter int COUNT_WIDTH  = 24,
  parameter int PULSE_CYCLES = 25,
  parameter int SETUP_CYCLES = 13,
  localparam int ADDR_WIDTH  = $clog2(NUM_CHANNELS * 4)
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    enable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  output logic                    ready,
  output logic [NUM_CHANNELS-1:0] step_out,
  output logic [NUM_CHANNELS-1:0] dir_out,
  output logic [NUM_CHANNELS-1:0] busy_out
);

  localparam int c_CH_WIDTH   = ADDR_WIDTH - 2;
  localparam int c_NUM_WORDS  = NUM_CHANNELS * 4;
  localparam int c_MIN_PERIOD = 2 * PULSE_CYCLES;
  localparam int c_W_MIN      = $clog2(c_MIN_PERIOD + 1);
  localparam int c_W_SETUP    = $clog2(SETUP_CYCLES + 1);
  localparam int c_W_A        = (PERIOD_WIDTH > c_W_MIN) ? PERIOD_WIDTH : c_W_MIN;
  localparam int c_CNT_WIDTH  = (c_W_A > c_W_SETUP) ? c_W_A : c_W_SETUP;

  localparam logic [c_CNT_WIDTH-1:0] c_SETUP_LAST = c_CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_PULSE_LAST = c_CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_MIN_EFF    = c_CNT_WIDTH'(c_MIN_PERIOD);
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE    = c_CNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] c_STEP_ONE   = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  logic                  r_served;
  logic                  w_access;
  logic                  w_in_range;
  logic [c_CH_WIDTH-1:0] w_ch;
  logic [1:0]            w_reg;
  logic [31:0]           w_rd_data;
  logic [31:0]           w_ch_rd [NUM_CHANNELS];
  logic                  w_unused_data;

  assign w_ch          = addr_in[ADDR_WIDTH-1:2];
  assign w_reg         = addr_in[1:0];
  assign w_in_range    = ({1'b0, addr_in} < (ADDR_WIDTH + 1)'(c_NUM_WORDS));
  // r_served blocks a second access while the same enable stays asserted
  assign w_access      = enable && !ready && !r_served;
  assign w_unused_data = ^data_in;

  always_comb begin
    w_rd_data = 32'd0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_in_range && (int'(w_ch) == c)) w_rd_data = w_ch_rd[c];
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ready    <= 1'b0;
      data_out <= 32'd0;
      r_served <= 1'b0;
    end else begin
      ready    <= w_access;
      data_out <= w_access ? w_rd_data : 32'd0;
      r_served <= enable && (r_served || w_access);
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_CNT_WIDTH-1:0]   r_cnt;
    logic [c_CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [c_CNT_WIDTH-1:0]   r_eff;
    logic [c_CNT_WIDTH-1:0]   w_eff_nxt;
    logic [c_CNT_WIDTH-1:0]   w_eff_now;
    logic [PERIOD_WIDTH-1:0]  r_period;
    logic [COUNT_WIDTH-1:0]   r_steps;
    logic [COUNT_WIDTH-1:0]   w_steps_nxt;
    logic                     r_dir, w_dir_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_stop, w_stop_nxt;
    logic                     r_step, r_busy;
    logic                     w_finish;
    logic                     w_sel, w_wr_ctrl, w_wr_period, w_wr_steps, w_wr_status;
    logic                     w_start, w_stop;

    assign w_sel       = w_access && write && w_in_range && (int'(w_ch) == g);
    assign w_wr_ctrl   = w_sel && (w_reg == 2'd0);
    assign w_wr_period = w_sel && (w_reg == 2'd1);
    assign w_wr_steps  = w_sel && (w_reg == 2'd2);
    assign w_wr_status = w_sel && (w_reg == 2'd3);
    assign w_start     = w_wr_ctrl && data_in[0];
    assign w_stop      = w_wr_ctrl && data_in[2];
    assign w_eff_now   = (c_CNT_WIDTH'(r_period) < c_MIN_EFF) ? c_MIN_EFF
                                                              : c_CNT_WIDTH'(r_period);

    // r_cnt is the zero-based phase since entering SETUP or since the last rise
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_eff_nxt   = r_eff;
      w_steps_nxt = r_steps;
      w_dir_nxt   = r_dir;
      w_done_nxt  = r_done;
      w_stop_nxt  = r_stop;
      w_finish    = 1'b0;
      if (w_wr_status && data_in[1]) w_done_nxt = 1'b0;
      if (w_wr_steps && (r_state == S_IDLE)) w_steps_nxt = data_in[COUNT_WIDTH-1:0];
      case (r_state)
        S_SETUP: begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
          end else if (r_cnt == c_SETUP_LAST) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = '0;
            w_eff_nxt   = w_eff_now;
            w_steps_nxt = r_steps - c_STEP_ONE;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_PULSE: begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
          if (w_stop) w_stop_nxt = 1'b1;
          if (r_cnt == c_PULSE_LAST) begin
            if (w_stop || r_stop) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b0;
              w_stop_nxt  = 1'b0;
            end else if (r_steps == '0) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_finish    = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
          end else if (r_cnt == (r_eff - c_CNT_ONE)) begin
            if (r_steps == '0) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_finish    = 1'b1;
            end else begin
              w_state_nxt = S_PULSE;
              w_cnt_nxt   = '0;
              w_eff_nxt   = w_eff_now;
              w_steps_nxt = r_steps - c_STEP_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        default: ;
      endcase
      // A start landing on the same edge as a normal finish is honoured
      if (w_start && !w_stop && ((r_state == S_IDLE) || w_finish)) begin
        w_dir_nxt  = data_in[1];
        w_stop_nxt = 1'b0;
        if (r_steps == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_eff    <= '0;
        r_period <= '0;
        r_steps  <= '0;
        r_dir    <= 1'b0;
        r_done   <= 1'b0;
        r_stop   <= 1'b0;
        r_step   <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_eff   <= w_eff_nxt;
        r_steps <= w_steps_nxt;
        r_dir   <= w_dir_nxt;
        r_done  <= w_done_nxt;
        r_stop  <= w_stop_nxt;
        r_step  <= (w_state_nxt == S_PULSE);
        r_busy  <= (w_state_nxt != S_IDLE);
        if (w_wr_period) r_period <= data_in[PERIOD_WIDTH-1:0];
      end
    end

    assign step_out[g] = r_step;
    assign dir_out[g]  = r_dir;
    assign busy_out[g] = r_busy;
    assign w_ch_rd[g]  = (w_reg == 2'd0) ? {30'd0, r_dir, 1'b0} :
                         (w_reg == 2'd1) ? 32'(r_period) :
                         (w_reg == 2'd2) ? 32'(r_steps) :
                                           {30'd0, r_done, r_busy};
  end

endmodule
`default_nettype wire

// File: tb/tb_step_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_generator
// Purpose  : Directed self-checking bench for step_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_generator;
  localparam int NCH = 12;
  localparam int AW  = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic           write = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic           ready;
  logic [NCH-1:0] step, dir, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  logic [NCH-1:0] wr_dir, wr_busy;

  int rise_t [NCH][16];
  int fall_t [NCH][16];
  int rise_n [NCH];
  int fall_n [NCH];
  logic [NCH-1:0] prev_step = '0;
  logic [NCH-1:0] busy_seen = '0;
  logic prev_ready = 1'b0;
  logic ready_long = 1'b0;

  step_generator #(
    .NUM_CHANNELS(NCH), .PERIOD_WIDTH(16), .COUNT_WIDTH(24),
    .PULSE_CYCLES(25), .SETUP_CYCLES(13)
  ) dut (
    .clk_in(clk), .reset_n_in(rst_n), .enable(enable), .write(write),
    .addr_in(addr), .data_in(wdata), .data_out(rdata), .ready(ready),
    .step_out(step), .dir_out(dir), .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (step[c] && !prev_step[c]) begin
        if (rise_n[c] < 16) rise_t[c][rise_n[c]] = cyc;
        rise_n[c]++;
      end
      if (!step[c] && prev_step[c]) begin
        if (fall_n[c] < 16) fall_t[c][fall_n[c]] = cyc;
        fall_n[c]++;
      end
    end
    prev_step = step;
    busy_seen = busy_seen | busy;
    if (ready && prev_ready) ready_long = 1'b1;
    prev_ready = ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    for (int c = 0; c < NCH; c++) begin
      rise_n[c] = 0;
      fall_n[c] = 0;
      for (int k = 0; k < 16; k++) begin
        rise_t[c][k] = 0;
        fall_t[c][k] = 0;
      end
    end
    busy_seen = '0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    enable = 1'b1; write = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_cyc = cyc; wr_dir = dir; wr_busy = busy;
    @(negedge clk);
    enable = 1'b0; write = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d, output logic rdy);
    enable = 1'b1; write = 1'b0; addr = a;
    @(posedge clk); #1;
    d = rdata; rdy = ready;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    enable = 1'b1; write = 1'b0; addr = 6'd1;
    repeat (3) @(negedge clk);
    checks++; if (step !== '0) begin errors++; $display("FAIL reset_step: got %h expected 0", step); end
    checks++; if (dir !== '0) begin errors++; $display("FAIL reset_dir: got %h expected 0", dir); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL first_access_ready: got %b expected 1", ready); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL first_access_data: got %h expected 0", rdata); end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d; logic r; int w;
    clear_mon();
    bus_write(6'd1, 32'd100);
    bus_write(6'd2, 32'd3);
    bus_write(6'd0, 32'h3);
    w = wr_cyc;
    checks++; if (wr_dir[0] !== 1'b1) begin errors++; $display("FAIL basic_dir_on_write: got %b expected 1", wr_dir[0]); end
    checks++; if (wr_busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_on_write: got %b expected 1", wr_busy[0]); end
    wait_until(w + 50);
    bus_read(6'd2, d, r);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL basic_steps_remaining: got %0d expected 2", d); end
    wait_until(w + 237);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_last_pulse: got %b expected 1", busy[0]); end
    wait_until(w + 238);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_after_fall: got %b expected 0", busy[0]); end
    wait_until(w + 260);
    checks++; if (rise_n[0] != 3) begin errors++; $display("FAIL basic_rise_count: got %0d expected 3", rise_n[0]); end
    checks++; if (rise_t[0][0] != w + 13) begin errors++; $display("FAIL basic_first_rise: got %0d expected %0d", rise_t[0][0], w + 13); end
    checks++; if (rise_t[0][1] - rise_t[0][0] != 100) begin errors++; $display("FAIL basic_period1: got %0d expected 100", rise_t[0][1] - rise_t[0][0]); end
    checks++; if (rise_t[0][2] - rise_t[0][1] != 100) begin errors++; $display("FAIL basic_period2: got %0d expected 100", rise_t[0][2] - rise_t[0][1]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fall_t[0][k] - rise_t[0][k] != 25) begin
        errors++; $display("FAIL basic_width%0d: got %0d expected 25", k, fall_t[0][k] - rise_t[0][k]);
      end
    end
    bus_read(6'd3, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status: got %h expected 2", d); end
    bus_read(6'd0, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_ctrl: got %h expected 2", d); end
    bus_read(6'd2, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL basic_steps_end: got %0d expected 0", d); end
  endtask

  task automatic test_clamp();
    int w;
    clear_mon();
    bus_write(6'd5, 32'd10);
    bus_write(6'd6, 32'd2);
    bus_write(6'd4, 32'h1);
    w = wr_cyc;
    wait_until(w + 150);
    checks++; if (rise_n[1] != 2) begin errors++; $display("FAIL clamp_count: got %0d expected 2", rise_n[1]); end
    checks++; if (rise_t[1][0] != w + 13) begin errors++; $display("FAIL clamp_first_rise: got %0d expected %0d", rise_t[1][0], w + 13); end
    checks++; if (rise_t[1][1] - rise_t[1][0] != 50) begin errors++; $display("FAIL clamp_period: got %0d expected 50", rise_t[1][1] - rise_t[1][0]); end
    checks++; if (dir[1] !== 1'b0) begin errors++; $display("FAIL clamp_dir: got %b expected 0", dir[1]); end
  endtask

  task automatic test_stop();
    logic [31:0] d; logic r; int w;
    clear_mon();
    bus_write(6'd9, 32'd100);
    bus_write(6'd10, 32'd10);
    bus_write(6'd8, 32'h1);
    w = wr_cyc;
    wait_until(w + 117);
    bus_write(6'd8, 32'h4);
    checks++; if (wr_cyc != w + 118) begin errors++; $display("FAIL stop_write_edge: got %0d expected %0d", wr_cyc, w + 118); end
    wait_until(w + 300);
    checks++; if (rise_n[2] != 2) begin errors++; $display("FAIL stop_rise_count: got %0d expected 2", rise_n[2]); end
    checks++; if (fall_t[2][1] - rise_t[2][1] != 25) begin errors++; $display("FAIL stop_width: got %0d expected 25", fall_t[2][1] - rise_t[2][1]); end
    bus_read(6'd10, d, r);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL stop_steps: got %0d expected 8", d); end
    bus_read(6'd11, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stop_status: got %h expected 0", d); end
  endtask

  task automatic test_zero_steps();
    logic [31:0] d; logic r; int w;
    clear_mon();
    bus_write(6'd16, 32'h1);
    w = wr_cyc;
    checks++; if (wr_busy[4] !== 1'b0) begin errors++; $display("FAIL zero_busy_on_write: got %b expected 0", wr_busy[4]); end
    wait_until(w + 40);
    checks++; if (rise_n[4] != 0) begin errors++; $display("FAIL zero_rises: got %0d expected 0", rise_n[4]); end
    checks++; if (busy_seen[4] !== 1'b0) begin errors++; $display("FAIL zero_busy_seen: got %b expected 0", busy_seen[4]); end
    bus_read(6'd19, d, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL zero_status_done: got %h expected 2", d); end
    bus_write(6'd19, 32'h2);
    bus_read(6'd19, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_clear: got %h expected 0", d); end
  endtask

  task automatic test_independent();
    logic [31:0] d; logic r; int w0, w1, nrdy;
    clear_mon();
    bus_write(6'd1, 32'd60);
    bus_write(6'd2, 32'd3);
    bus_write(6'd45, 32'd90);
    bus_write(6'd46, 32'd3);
    bus_write(6'd0, 32'h3);
    w0 = wr_cyc;
    bus_write(6'd44, 32'h1);
    w1 = wr_cyc;
    bus_write(6'd0, 32'h1);
    checks++; if (wr_dir[0] !== 1'b1) begin errors++; $display("FAIL busy_start_ignored_dir: got %b expected 1", wr_dir[0]); end
    bus_write(6'd2, 32'd100);
    bus_read(6'd50, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", r); end
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oor_data: got %h expected 0", d); end
    bus_write(6'd52, 32'hFFFF_FFFF);
    nrdy = 0;
    enable = 1'b1; write = 1'b0; addr = 6'd45;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) nrdy++;
    end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++; if (nrdy != 1) begin errors++; $display("FAIL held_enable_ready: got %0d expected 1", nrdy); end
    wait_until(w1 + 250);
    checks++; if (rise_n[0] != 3) begin errors++; $display("FAIL ind_ch0_count: got %0d expected 3", rise_n[0]); end
    checks++; if (rise_n[11] != 3) begin errors++; $display("FAIL ind_ch11_count: got %0d expected 3", rise_n[11]); end
    checks++; if (rise_t[0][0] != w0 + 13) begin errors++; $display("FAIL ind_ch0_first: got %0d expected %0d", rise_t[0][0], w0 + 13); end
    checks++; if (rise_t[0][2] - rise_t[0][0] != 120) begin errors++; $display("FAIL ind_ch0_span: got %0d expected 120", rise_t[0][2] - rise_t[0][0]); end
    checks++; if (rise_t[11][0] != w1 + 13) begin errors++; $display("FAIL ind_ch11_first: got %0d expected %0d", rise_t[11][0], w1 + 13); end
    checks++; if (rise_t[11][2] - rise_t[11][0] != 180) begin errors++; $display("FAIL ind_ch11_span: got %0d expected 180", rise_t[11][2] - rise_t[11][0]); end
    checks++; if (dir[0] !== 1'b1) begin errors++; $display("FAIL ind_ch0_dir: got %b expected 1", dir[0]); end
    checks++; if (ready_long !== 1'b0) begin errors++; $display("FAIL ready_single_cycle: got %b expected 0", ready_long); end
    bus_read(6'd2, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ind_ch0_steps: got %0d expected 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic r; int w;
    clear_mon();
    bus_write(6'd13, 32'd100);
    bus_write(6'd14, 32'd5);
    bus_write(6'd12, 32'h1);
    w = wr_cyc;
    wait_until(w + 20);
    checks++; if (step[3] !== 1'b1) begin errors++; $display("FAIL mid_pulse_high: got %b expected 1", step[3]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (step[3] !== 1'b0) begin errors++; $display("FAIL async_step_drop: got %b expected 0", step[3]); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL async_busy: got %h expected 0", busy); end
    checks++; if (dir !== '0) begin errors++; $display("FAIL async_dir: got %h expected 0", dir); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 12; k < 16; k++) begin
      bus_read(AW'(k), d, r);
      checks++;
      if (d !== 32'd0 || r !== 1'b1) begin
        errors++; $display("FAIL post_reset_reg%0d: got %h/%b expected 0/1", k, d, r);
      end
    end
    bus_read(6'd1, d, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_reset_ch0_period: got %0d expected 0", d); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_clamp();
    test_stop();
    test_zero_steps();
    test_independent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
